// File: rtl/pwm_ramp_controller_pkg.sv
// Shared definitions for the PWM duty ramp controller and the PWM generator it drives.
package pwm_ctrl_pkg;
  localparam int DW_DEF            = 8;
  localparam int PERIOD_CYCLES_DEF = 256;
  localparam int DWELL_W_DEF       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;
endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Command, control and duty/status signals between config logic, ramp controller and PWM.
interface pwm_ramp_controller_if
  import pwm_ctrl_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);
  logic               enable;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [DW-1:0]      cmd_target;
  logic [DW-1:0]      cmd_step;
  logic [DWELL_W-1:0] cmd_dwell;
  logic               abort;
  logic [DW-1:0]      duty_cycle;
  logic               period_start;
  logic               busy;
  logic               done;

  modport master (
    output enable, cmd_valid, cmd_target, cmd_step, cmd_dwell, abort,
    input  cmd_ready, duty_cycle, period_start, busy, done
  );

  modport slave (
    input  enable, cmd_valid, cmd_target, cmd_step, cmd_dwell, abort,
    output cmd_ready, duty_cycle, period_start, busy, done
  );
endinterface

// File: rtl/pwm_ramp_controller_timer.sv
// Free-running PWM period counter; frozen at zero while disabled.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int  PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  localparam int CW            = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_boundary,
  output logic o_period_start
);
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_enable || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_boundary     = i_enable && w_last;
  // rst_n gate keeps period_start low for the whole reset, not just after the first edge
  assign o_period_start = rst_n && i_enable && (r_cnt == '0);
endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramps the PWM duty toward a commanded target in bounded steps on period boundaries.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DW            = DW_DEF,
  parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int DWELL_W       = DWELL_W_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  pwm_ramp_controller_if.slave s_if
);
  ramp_state_e        r_state, w_state_nxt;
  logic [DW-1:0]      r_duty, w_duty_nxt;
  logic [DW-1:0]      r_target, w_target_nxt;
  logic [DW-1:0]      r_step, w_step_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
  logic               r_done, w_done_nxt;
  logic               w_boundary;
  logic               w_period_start;
  logic [DW:0]        w_sum;
  logic [DW-1:0]      w_stepped;

  pwm_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (s_if.enable),
    .o_boundary     (w_boundary),
    .o_period_start (w_period_start)
  );

  // Extra sum bit keeps an upward step from wrapping past full scale
  assign w_sum = {1'b0, r_duty} + {1'b0, r_step};

  always_comb begin
    w_stepped = r_target;
    if (r_target > r_duty) begin
      if (w_sum < {1'b0, r_target}) w_stepped = w_sum[DW-1:0];
    end else if ((r_duty - r_target) > r_step) begin
      w_stepped = r_duty - r_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_duty      <= '0;
      r_target    <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_duty      <= w_duty_nxt;
      r_target    <= w_target_nxt;
      r_step      <= w_step_nxt;
      r_dwell     <= w_dwell_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_duty_nxt      = r_duty;
    w_target_nxt    = r_target;
    w_step_nxt      = r_step;
    w_dwell_nxt     = r_dwell;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_done_nxt      = 1'b0;
    if (!s_if.enable) begin
      w_state_nxt     = IDLE;
      w_duty_nxt      = '0;
      w_dwell_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.cmd_valid) begin
            w_target_nxt    = s_if.cmd_target;
            w_step_nxt      = (s_if.cmd_step == '0) ? DW'(1) : s_if.cmd_step;
            w_dwell_nxt     = (s_if.cmd_dwell == '0) ? DWELL_W'(1) : s_if.cmd_dwell;
            w_dwell_cnt_nxt = '0;
            if (s_if.cmd_target == r_duty) w_done_nxt  = 1'b1;
            else                           w_state_nxt = RAMP;
          end
        end
        RAMP: begin
          if (s_if.abort) begin
            w_state_nxt = IDLE;
          end else if (w_boundary) begin
            if (r_dwell_cnt == r_dwell - 1'b1) begin
              w_duty_nxt      = w_stepped;
              w_dwell_cnt_nxt = '0;
              if (w_stepped == r_target) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign s_if.duty_cycle   = r_duty;
  assign s_if.period_start = w_period_start;
  assign s_if.busy         = (r_state == RAMP);
  assign s_if.done         = r_done;
  assign s_if.cmd_ready    = rst_n && s_if.enable && (r_state == IDLE);
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed plus randomized ramp commands checked against a per-boundary duty model.
module tb_pwm_ramp_controller;
  import pwm_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int PER = 16;
  localparam int DWW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   m_duty   = 0;

  pwm_ramp_controller_if #(.DW(DW), .DWELL_W(DWW)) bus ();

  pwm_ramp_controller #(.DW(DW), .PERIOD_CYCLES(PER), .DWELL_W(DWW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Duty after one step from d toward t, using plain integer arithmetic
  function automatic int model_step(int d, int t, int s);
    if (t > d) return (d + s > t) ? t : d + s;
    return (d - t <= s) ? t : d - s;
  endfunction

  task automatic send_cmd(input int t, input int s, input int dw, input bit ab);
    int waited;
    logic [31:0] tv, sv, dv;
    waited = 0;
    tv = t; sv = s; dv = dw;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tv[7:0];
    bus.cmd_step   = sv[7:0];
    bus.cmd_dwell  = dv[7:0];
    bus.abort      = ab;
    while (bus.cmd_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) check("cmd_ready_timeout", waited, 0);
    tick();
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic run_ramp(input int t, input int s, input int dw, input bit ab);
    int se, de, b, budget;
    bit fin;
    se  = (s == 0) ? 1 : s;
    de  = (dw == 0) ? 1 : dw;
    b   = 0;
    fin = 1'b0;
    if (t == m_duty) begin
      send_cmd(t, s, dw, ab);
      check("done_equal", bus.done, 1);
      check("busy_equal", bus.busy, 0);
      tick();
      check("done_equal_once", bus.done, 0);
      return;
    end
    send_cmd(t, s, dw, ab);
    check("busy_start", bus.busy, 1);
    budget = PER * de * 260;
    for (int c = 0; c < budget && !fin; c++) begin
      tick();
      if (bus.period_start === 1'b1) begin
        b++;
        if (b % de == 0) m_duty = model_step(m_duty, t, se);
        fin = (m_duty == t);
      end
      check("duty", bus.duty_cycle, m_duty);
      check("done", bus.done, fin);
      check("busy", bus.busy, !fin);
    end
    if (!fin) check("ramp_timeout", 0, 1);
    check("ready_after_done", bus.cmd_ready, 1);
    tick();
    check("done_pulse_once", bus.done, 0);
  endtask

  initial begin
    int ps, t, s, dw;
    bus.enable = 1'b0; bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    bus.cmd_target = '0; bus.cmd_step = '0; bus.cmd_dwell = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_duty", bus.duty_cycle, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_pstart", bus.period_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    tick();
    check("ready_idle", bus.cmd_ready, 1);

    run_ramp(64, 16, 1, 1'b0);
    run_ramp(10, 32, 1, 1'b0);
    run_ramp(250, 255, 1, 1'b0);
    run_ramp(255, 200, 1, 1'b0);
    run_ramp(0, 255, 0, 1'b0);
    run_ramp(2, 1, 3, 1'b0);
    run_ramp(2, 5, 1, 1'b0);
    run_ramp(0, 0, 0, 1'b0);

    // Abort on the boundary cycle that would have stepped 32 -> 48
    send_cmd(64, 16, 1, 1'b0);
    ps = 0;
    for (int c = 0; c < 200 && ps < 2; c++) begin
      tick();
      if (bus.period_start === 1'b1) ps++;
    end
    check("abort_pre_duty", bus.duty_cycle, 32);
    repeat (15) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_duty", bus.duty_cycle, 32);
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_done", bus.done, 0);
    for (int c = 0; c < 40; c++) begin
      tick();
      check("abort_hold_duty", bus.duty_cycle, 32);
      check("abort_hold_done", bus.done, 0);
    end
    m_duty = 32;
    run_ramp(0, 0, 1, 1'b0);

    // Abort asserted in IDLE alongside a command is ignored
    run_ramp(40, 20, 1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      dw = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        s = 0;
        t = m_duty ^ int'($urandom_range(0, 15));
      end else begin
        s = $urandom_range(8, 255);
        t = $urandom_range(0, 255);
      end
      run_ramp(t, s, dw, 1'b0);
    end

    // enable low mid-ramp: duty clears, counter frozen, restarts at 0
    send_cmd((m_duty == 200) ? 100 : 200, 1, 1, 1'b0);
    repeat (20) tick();
    bus.enable = 1'b0;
    tick();
    check("dis_duty", bus.duty_cycle, 0);
    check("dis_busy", bus.busy, 0);
    check("dis_ready", bus.cmd_ready, 0);
    check("dis_done", bus.done, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("dis_pstart", bus.period_start, 0);
      check("dis_hold_duty", bus.duty_cycle, 0);
    end
    bus.enable = 1'b1;
    #1;
    check("reen_pstart", bus.period_start, 1);
    check("reen_ready", bus.cmd_ready, 1);
    for (int k = 1; k <= PER; k++) begin
      tick();
      check("reen_period", bus.period_start, (k == PER));
    end
    m_duty = 0;

    // Asynchronous reset in the middle of a cycle
    send_cmd(100, 1, 1, 1'b0);
    repeat (20) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_duty", bus.duty_cycle, 0);
    check("arst_pstart", bus.period_start, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_ready", bus.cmd_ready, 0);
    check("arst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.cmd_ready, 1);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_duty", bus.duty_cycle, 0);
    m_duty = 0;
    run_ramp(3, 2, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
